pipeline_8bit_subtractor: RTL and testbench
===========================================

Name: pipeline_8bit_subtractor

Overview:
- Two-stage pipelined unsigned/two's-complement subtractor computing diff = a - b - bin, split at the nibble boundary.
- It is the inverse-direction companion of the pipelined 8-bit adder. It is used where the datapath needs sum-then-difference recovery.
- Single clock domain with a valid/ready handshake on both sides. Full throughput of one op per cycle; stalls cleanly under backpressure.

Parameters:
- WIDTH, 8, operand width. Must be even and ≥ 4. The low stage handles WIDTH/2 bits; the high stage handles the rest.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset: 0 resets, 1 runs.
- in_valid  input  1  operands a/b/bin are valid this cycle.
- in_ready  output  1  the block accepts the operands this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  the result registers hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- diff  output  WIDTH  result, (a - b - bin) mod 2^WIDTH.
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned).
- zero  output  1  diff == 0, after the optional saturation.
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and raw diff[MSB] != a[MSB].

Behaviour:
- Reset (rst=0, asynchronous): all valid flags 0, diff=0, bout=0, zero=0, ovf=0, in_ready=1 after reset. Pipeline contents are discarded.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage 1 register (v1):
  - Captures lo = a[WIDTH/2-1:0] - b[WIDTH/2-1:0] - bin.
  - Captures the internal borrow br1, a_hi, b_hi, and the a/b MSBs.
- Stage 2 register (v2, equal to out_valid):
  - hi = a_hi - b_hi - br1.
  - diff = {hi, lo}; bout is the high-nibble borrow; zero and ovf are computed from the final diff.
- Advance rules:
  - adv2 = v1 && (!v2 || out_ready).
  - adv1 = in_valid && in_ready.
  - in_ready = !v1 || adv2, combinational from registered state and out_ready only.
  - No combinational path exists from in_valid to in_ready.
- Valid updates:
  - v2 next = adv2 ? 1 : (out_ready ? 0 : v2).
  - v1 next = adv1 ? 1 : (adv2 ? 0 : v1).
- Latency: a result is visible on out_valid exactly 2 cycles after input acceptance when out_ready stays high. Throughput is 1 op/cycle.
- Backpressure:
  - With out_ready=0, outputs hold stable and unchanged, and the pipeline fills.
  - After 2 accepted ops, in_ready=0.
  - No op is dropped or duplicated.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 shifts both stages and accepts the new op in the same cycle.
- Ordering: results leave in the order the ops were accepted.
- Wrap-around: arithmetic is modulo 2^WIDTH. The borrow chain spans both stages, e.g. 0x10 - 0x01 borrows across the nibble boundary.
- Reset mid-operation: in-flight ops are lost, out_valid drops asynchronously, and no partial result is presented.

Optional Feature:
- Macro SUB_SATURATE_EN.
- Defined: unsigned saturating mode. When the final borrow is 1, diff is forced to 0 and zero=1; bout still reports 1 and ovf is computed from the unsaturated result. Saturation is applied in stage 2 and adds no latency.
- Undefined: diff is the plain modular result. No saturation logic is present.

Test Plan:
- Reset then basic subtract: a=0x5A, b=0x23, bin=0, out_ready=1 -> 2 cycles later diff=0x37, bout=0, zero=0, ovf=0.
- Cross-nibble borrow and wrap: a=0x10, b=0x01, bin=1 -> diff=0x0E, bout=0. Then a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; with SUB_SATURATE_EN: diff=0x00, zero=1, bout=1.
- Signed overflow: a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0. Also a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1.
- Backpressure: stream 4 ops with out_ready=0 -> in_ready falls after 2 accepts and diff holds stable. Release out_ready=1 -> all 4 results emerge in order, none lost or duplicated.
- Full throughput: 16 back-to-back random ops with out_ready=1 -> one result per cycle, each matching a golden (a-b-bin) model including bout/zero/ovf.
- Async reset mid-stream: assert rst=0 between clock edges with both stages full -> out_valid=0 immediately. After release, in_ready=1 and the next op completes with latency 2.

Source files
------------

// File: rtl/pipeline_8bit_subtractor.sv
// pipeline_8bit_subtractor: two-stage pipelined a - b - bin, split at the half-width boundary.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready, a, b, bin     : operand handshake
//   out_valid/out_ready, diff, bout  : result handshake, borrow-out
//   zero, ovf                        : diff == 0, signed overflow
// Optional macro SUB_SATURATE_EN: unsigned saturation (diff forced to 0 on final borrow).
module pipeline_8bit_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);
  localparam int H = WIDTH / 2;
  localparam int L = WIDTH - H;
  logic             v1, br1, adv1, adv2;
  logic [H-1:0]     lo1;
  logic [L-1:0]     a_hi, b_hi;
  logic [H:0]       lo_n;
  logic [L:0]       hi_n;
  logic [WIDTH-1:0] raw, res;
  assign adv2     = v1 && (!out_valid || out_ready);
  assign in_ready = !v1 || adv2;
  assign adv1     = in_valid && in_ready;
  // the extra top bit of each half-subtraction is its borrow
  assign lo_n = {1'b0, a[H-1:0]} - {1'b0, b[H-1:0]} - (H+1)'(bin);
  assign hi_n = {1'b0, a_hi} - {1'b0, b_hi} - (L+1)'(br1);
  assign raw  = {hi_n[L-1:0], lo1};
`ifdef SUB_SATURATE_EN
  assign res = hi_n[L] ? '0 : raw;
`else
  assign res = raw;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1        <= 1'b0;
      lo1       <= '0;
      br1       <= 1'b0;
      a_hi      <= '0;
      b_hi      <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      v1        <= adv1 ? 1'b1 : (adv2 ? 1'b0 : v1);
      out_valid <= adv2 ? 1'b1 : (out_ready ? 1'b0 : out_valid);
      if (adv1) begin
        lo1  <= lo_n[H-1:0];
        br1  <= lo_n[H];
        a_hi <= a[WIDTH-1:H];
        b_hi <= b[WIDTH-1:H];
      end
      if (adv2) begin
        diff <= res;
        bout <= hi_n[L];
        zero <= res == '0;
        // overflow uses the unsaturated result
        ovf  <= (a_hi[L-1] != b_hi[L-1]) && (raw[WIDTH-1] != a_hi[L-1]);
      end
    end
  end
endmodule

// File: tb/tb_pipeline_8bit_subtractor.sv
// tb_pipeline_8bit_subtractor: directed and random checks of the pipelined subtractor against a queue model.
module tb_pipeline_8bit_subtractor;
  logic       clk = 0, rst = 0, in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [7:0] a = 0, b = 0, diff;
  logic       bin = 0, bout, zero, ovf;
  int         checks = 0, failures = 0, in_cnt = 0, out_cnt = 0;
  logic [10:0] q[$];
  logic        hold = 0;
  logic [10:0] held;

  pipeline_8bit_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] gold(input logic [7:0] x, input logic [7:0] y, input logic c);
    int d;
    logic [7:0] r, o;
    logic br, ov;
    d  = int'(x) - int'(y) - int'(c);
    br = d < 0;
    r  = 8'(d & 255);
    ov = (x[7] != y[7]) && (r[7] != x[7]);
    o  = r;
`ifdef SUB_SATURATE_EN
    if (br) o = 8'h00;
`endif
    return {o, br, o == 8'h00, ov};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: ops are modelled at acceptance and retired in order at output transfer
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      hold = 0;
    end else begin
      if (hold && out_valid) begin
        checks++;
        if ({diff, bout, zero, ovf} !== held) begin
          failures++;
          $display("FAIL hold_stable: got %h expected %h", {diff, bout, zero, ovf}, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        out_cnt++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL extra_result: got %h expected none", {diff, bout, zero, ovf});
        end else begin
          logic [10:0] e;
          e = q.pop_front();
          if ({diff, bout, zero, ovf} !== e) begin
            failures++;
            $display("FAIL result: got diff=%h bout=%b zero=%b ovf=%b expected diff=%h bout=%b zero=%b ovf=%b",
                     diff, bout, zero, ovf, e[10:3], e[2], e[1], e[0]);
          end
        end
      end
      hold = out_valid && !out_ready;
      held = {diff, bout, zero, ovf};
      if (in_valid && in_ready) begin
        q.push_back(gold(a, b, bin));
        in_cnt++;
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic acc;
    int n = 0;
    in_valid = 1; a = x; b = y; bin = c;
    forever begin
      @(negedge clk) acc = in_ready;
      @(posedge clk) #1;
      if (acc) break;
      if (++n > 50) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk) #1;
      n++;
    end
    chk("drain_timeout", n < 50, 1);
  endtask

  task automatic latency_op(input logic [7:0] x, input logic [7:0] y, input logic c);
    int cnt;
    in_valid = 1; a = x; b = y; bin = c;
    @(posedge clk) #1;
    in_valid = 0;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(posedge clk) #1;
      cnt++;
    end
    chk("latency", cnt, 2);
  endtask

  logic [7:0]  va[7] = '{8'h5A, 8'h10, 8'h00, 8'h80, 8'h7F, 8'h33, 8'h33};
  logic [7:0]  vb[7] = '{8'h23, 8'h01, 8'h01, 8'h01, 8'hFF, 8'h33, 8'h32};
  logic        vc[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef SUB_SATURATE_EN
  logic [10:0] ve[7] = '{{8'h37, 3'b000}, {8'h0E, 3'b000}, {8'h00, 3'b110}, {8'h7F, 3'b001},
                         {8'h00, 3'b111}, {8'h00, 3'b010}, {8'h00, 3'b010}};
`else
  logic [10:0] ve[7] = '{{8'h37, 3'b000}, {8'h0E, 3'b000}, {8'hFF, 3'b100}, {8'h7F, 3'b001},
                         {8'h80, 3'b101}, {8'h00, 3'b010}, {8'h00, 3'b010}};
`endif

  initial begin
    logic [7:0] x, y;
    int t0, o0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1;
    for (int i = 0; i < 7; i++) chk($sformatf("model_vec%0d", i), gold(va[i], vb[i], vc[i]), ve[i]);
    latency_op(va[0], vb[0], vc[0]);
    chk("basic_diff", diff, 8'h37);
    drain();
    for (int i = 1; i < 7; i++) send(va[i], vb[i], vc[i]);
    drain();
    // backpressure: two accepts fill the pipe, the rest wait
    out_ready = 0;
    send(8'h12, 8'h34, 0);
    send(8'hA0, 8'h0F, 1);
    chk("bp_in_ready_low", in_ready, 0);
    in_valid = 1; a = 8'hFF; b = 8'h01; bin = 0;
    repeat (3) @(posedge clk) #1;
    chk("bp_still_blocked", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head_diff", {diff, bout, zero, ovf}, gold(8'h12, 8'h34, 0));
    out_ready = 1;
    send(8'hFF, 8'h01, 0);
    send(8'h01, 8'h02, 1);
    drain();
    chk("bp_counts", out_cnt, in_cnt);
    // full throughput
    t0 = $time; o0 = out_cnt;
    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      send(x, y, 1'($urandom_range(0, 1)));
    end
    chk("tp_cycles", ($time - t0) / 10, 16);
    drain();
    chk("tp_results", out_cnt - o0, 16);
    // async reset with both stages full
    out_ready = 0;
    send(8'h44, 8'h11, 0);
    send(8'h55, 8'h22, 0);
    #3 rst = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_diff", diff, 0);
    @(posedge clk) #1;
    rst = 1;
    out_ready = 1;
    latency_op(8'h33, 8'h32, 1);
    chk("post_rst_zero", zero, 1);
    drain();
    chk("final_counts", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
